// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit scheduler, baud generator and receiver:
// frame state encoding and the default frame geometry.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after the pointer
// (wrapping) and moves the pointer past the winner when the grant is taken.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               valid
);

  logic [ID_W-1:0] ptr;

  // Scan from farthest to nearest so the nearest set request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      automatic int j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = ID_W'(j);
        valid     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (advance && valid) begin
      ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART tx line between NUM_REQ byte sources: round-robin grant,
// byte capture and serialisation (start, LSB-first data, stop) on the 16x baud tick.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         tick,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] data,
  output logic [NUM_REQ-1:0]           ack,
  output logic [ID_W-1:0]              grant_id,
  output logic                         busy,
  output logic                         tx
);

  localparam int TICK_W = $clog2(OVERSAMPLE * STOP_BITS);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(OVERSAMPLE * STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_e          state, state_d;
  logic [TICK_W-1:0]    tick_cnt, tick_d;
  logic [BIT_W-1:0]     bit_cnt, bit_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_vld;
  logic                 advance;
  logic                 tx_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .advance   (advance),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .valid     (grant_vld)
  );

  // Ticks in IDLE and in the grant cycle never reach the counter, so the
  // start bit always spans a full OVERSAMPLE ticks after the grant edge.
  always_comb begin
    state_d = state;
    tick_d  = tick_cnt;
    bit_d   = bit_cnt;
    shift_d = shift;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          advance = 1'b1;
          state_d = START;
          tick_d  = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) shift_d = data[i*DATA_BITS +: DATA_BITS];
          end
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_cnt + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_d  = '0;
            shift_d = shift >> 1;
            bit_d   = bit_cnt + BIT_W'(1);
            if (bit_cnt == DATA_LAST) state_d = STOP;
          end else begin
            tick_d = tick_cnt + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == STOP_LAST) begin
            state_d = IDLE;
            tick_d  = '0;
          end else begin
            tick_d = tick_cnt + TICK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      ack      <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_d;
      tick_cnt <= tick_d;
      bit_cnt  <= bit_d;
      tx       <= tx_d;
      busy     <= (state_d != IDLE);
      ack      <= advance ? grant_oh : '0;
      if (advance) grant_id <= grant_idx;
    end
  end

  // The byte register only carries data; its content is meaningless until a grant loads it.
  always_ff @(posedge clock) begin
    shift <= shift_d;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed and random frames checked cycle by cycle
// against a tick-counting frame model and a round-robin grant model.
module tb_uart_tx_scheduler;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int OS = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          tick = 1'b0;
  logic [N-1:0]    req1 = '0, req2 = '0;
  logic [N*DB-1:0] data1 = '0, data2 = '0;
  logic [N-1:0]    ack1, ack2;
  logic [1:0]      gid1, gid2;
  logic            busy1, busy2, tx1, tx2;

  int compared   = 0;
  int mismatched = 0;
  int ptr_m[2];
  bit tick_en = 1'b1;

  uart_tx_scheduler #(
    .NUM_REQ(N), .ID_W(2), .DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(1)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .req(req1), .data(data1),
    .ack(ack1), .grant_id(gid1), .busy(busy1), .tx(tx1)
  );

  uart_tx_scheduler #(
    .NUM_REQ(N), .ID_W(2), .DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(2)
  ) dut2 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .req(req2), .data(data2),
    .ack(ack2), .grant_id(gid2), .busy(busy2), .tx(tx2)
  );

  always #5 clock = ~clock;

  initial begin : tickgen
    int ph;
    ph = 0;
    forever begin
      @(posedge clock);
      #1;
      tick = tick_en && (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] get_ack(input int u);
    return (u == 0) ? ack1 : ack2;
  endfunction
  function automatic logic [1:0] get_gid(input int u);
    return (u == 0) ? gid1 : gid2;
  endfunction
  function automatic logic get_busy(input int u);
    return (u == 0) ? busy1 : busy2;
  endfunction
  function automatic logic get_tx(input int u);
    return (u == 0) ? tx1 : tx2;
  endfunction

  task automatic set_req(input int u, input int g, input logic v);
    if (u == 0) req1[g] = v; else req2[g] = v;
  endtask
  task automatic set_data(input int u, input int g, input logic [DB-1:0] v);
    if (u == 0) data1[g*DB +: DB] = v; else data2[g*DB +: DB] = v;
  endtask

  // Round robin: first requester at or after the pointer, wrapping.
  function automatic int model_grant(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One frame: wait for the grant, then check tx/busy/ack every clock from the
  // number of ticks seen since the grant edge.
  task automatic do_frame(input int u, input int b2b, input int rearm,
                          input int abort_at, input int stall);
    int g, ticks, total, wait_n, sb, k, cyc;
    bit rearmed;
    logic [DB-1:0] byte_e;
    logic [N-1:0]  r;
    logic          exp_tx;
    sb    = (u == 0) ? 1 : 2;
    total = (1 + DB + sb) * OS;
    r     = (u == 0) ? req1 : req2;
    g     = model_grant(r, ptr_m[u]);
    if (g < 0) return;
    byte_e = (u == 0) ? data1[g*DB +: DB] : data2[g*DB +: DB];

    wait_n = 0;
    @(negedge clock);
    while (get_ack(u) == '0 && wait_n < 50) begin
      wait_n++;
      @(negedge clock);
    end
    if (b2b != 0) chk("b2b_gap", wait_n, 0);
    chk("ack_grant", get_ack(u), 4'b0001 << g);
    if (get_ack(u) == '0) return;
    chk("grant_id", get_gid(u), g);
    ptr_m[u] = (g + 1) % N;
    if (abort_at < 0) begin
      set_req(u, g, 1'b0);
      set_data(u, g, DB'($urandom));
    end

    ticks   = 0;
    cyc     = 0;
    rearmed = 1'b0;
    forever begin
      if (ticks >= total) begin
        chk("end_busy", get_busy(u), 0);
        chk("end_tx", get_tx(u), 1);
        break;
      end
      k = ticks / OS;
      exp_tx = (k == 0) ? 1'b0 : (k <= DB) ? byte_e[k-1] : 1'b1;
      chk("tx", get_tx(u), exp_tx);
      chk("busy", get_busy(u), 1);
      if (cyc > 0) chk("ack_pulse", get_ack(u), 0);
      if (abort_at >= 0 && ticks == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_tx", get_tx(u), 1);
        chk("rst_busy", get_busy(u), 0);
        chk("rst_ack", get_ack(u), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_hold_ack", get_ack(u), 0);
        reset_n  = 1'b1;
        ptr_m[0] = 0;
        ptr_m[1] = 0;
        return;
      end
      if (rearm != 0 && !rearmed && ticks == OS * 4) begin
        set_data(u, g, DB'($urandom));
        set_req(u, g, 1'b1);
        rearmed = 1'b1;
      end
      if (stall > 0 && cyc == 0) tick_en = 1'b0;
      if (stall > 0 && cyc == stall) tick_en = 1'b1;
      if (tick) ticks++;
      cyc++;
      @(negedge clock);
    end
  endtask

  initial begin
    bit first;
    ptr_m[0] = 0;
    ptr_m[1] = 0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_tx1", tx1, 1);
    chk("reset_ack1", ack1, 0);
    chk("reset_busy1", busy1, 0);
    chk("reset_gid1", gid1, 0);
    chk("reset_tx2", tx2, 1);
    chk("reset_busy2", busy2, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Single frame 0x55 from source 0
    data1[7:0] = 8'h55;
    req1 = 4'b0001;
    do_frame(0, 0, 0, -1, 0);

    // All sources requesting, re-raised once: 0,1,2,3,0,1,2,3
    data1 = $urandom;
    req1  = 4'b1111;
    for (int i = 0; i < 8; i++) do_frame(0, (i == 0) ? 0 : 1, (i < 4) ? 1 : 0, -1, 0);

    // Pointer moved to 2, then 1010 -> 3 then 1; pointer left at 2
    data1 = $urandom;
    req1  = 4'b0010;
    do_frame(0, 0, 0, -1, 0);
    req1 = 4'b1010;
    do_frame(0, 0, 0, -1, 0);
    do_frame(0, 1, 0, -1, 0);
    data1 = $urandom;
    req1  = 4'b1111;
    for (int i = 0; i < 4; i++) do_frame(0, (i == 0) ? 0 : 1, 0, -1, 0);

    // Reset in the middle of data bit 4 of 0xA3, then a full retransmission
    data1[7:0] = 8'hA3;
    req1 = 4'b0001;
    do_frame(0, 0, 0, OS * 5 + OS / 2, 0);
    do_frame(0, 0, 0, -1, 0);

    // Two stop bits, grant cycle coincident with a tick
    data2[7:0] = 8'hFF;
    @(posedge tick);
    req2 = 4'b0001;
    do_frame(1, 0, 0, -1, 0);

    // Tick stalls for 1000 clocks inside the start bit
    data1 = $urandom;
    req1  = 4'b0001;
    do_frame(0, 0, 0, -1, 1000);

    // Random request masks and bytes
    for (int r = 0; r < 6; r++) begin
      data1 = $urandom;
      req1  = 4'($urandom_range(1, 15));
      first = 1'b1;
      while (req1 != '0) begin
        do_frame(0, first ? 0 : 1, 0, -1, 0);
        first = 1'b0;
      end
    end

    repeat (4) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
